// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : default IF/ID widths, NOP opcode and field decoder       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package pipe_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_W     = 32;
  localparam int OPCODE_W = 4;
  localparam int REG_W    = 6;
  localparam int FIELD_W  = OPCODE_W + 3 * REG_W;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 4'b0000;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
  } if_id_fields_t;

  // Takes only the top FIELD_W bits of the instruction; low bits are immediates.
  function automatic if_id_fields_t decode(input logic [FIELD_W-1:0] hi);
    if_id_fields_t f;
    f.opcode = hi[FIELD_W-1 -: OPCODE_W];
    f.rd     = hi[FIELD_W-OPCODE_W-1 -: REG_W];
    f.rs     = hi[FIELD_W-OPCODE_W-REG_W-1 -: REG_W];
    f.rt     = hi[REG_W-1:0];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | skid_buf : 2-entry valid/ready register (output reg + skid reg)     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module skid_buf #(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              load,
  output logic [DATA_W-1:0] load_data
);

  logic              o_valid_q, o_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              accept, consume, o_free;

  always_comb begin
    accept    = in_valid && !s_valid_q;
    consume   = o_valid_q && out_ready;
    o_free    = !o_valid_q || consume;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    o_data_d  = o_data_q;
    s_data_d  = s_data_q;
    load      = 1'b0;
    // The skid entry is older than anything at the input, so it loads first.
    load_data = s_valid_q ? s_data_q : in_data;
    if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (o_free) begin
      if (s_valid_q || accept) begin
        load      = 1'b1;
        o_valid_d = 1'b1;
        o_data_d  = load_data;
        s_valid_d = 1'b0;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      o_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
      o_data_q  <= o_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready  = !s_valid_q;
  assign out_valid = o_valid_q;
  assign out_data  = o_data_q;

endmodule
`default_nettype wire

// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_id_pipe_reg : IF->ID pipeline register with skid buffer and      |
// | registered field decode. IF_ID_PIPE_REG_STATS_EN adds bubble_count. |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module if_id_pipe_reg #(
  parameter int INSTR_W  = pipe_pkg::INSTR_W,
  parameter int PC_W     = pipe_pkg::PC_W,
  parameter int OPCODE_W = pipe_pkg::OPCODE_W,
  parameter int REG_W    = pipe_pkg::REG_W,
  parameter logic [OPCODE_W-1:0] NOP_OPCODE = pipe_pkg::NOP_OPCODE
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [PC_W-1:0]     pc_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [PC_W-1:0]     pc_id,
`ifdef IF_ID_PIPE_REG_STATS_EN
  output logic [INSTR_W-1:0]  instr_id,
  output logic [15:0]         bubble_count
`else
  output logic [INSTR_W-1:0]  instr_id
`endif
);

  import pipe_pkg::*;

  localparam int DATA_W = PC_W + INSTR_W;

  if (OPCODE_W + 3 * REG_W > INSTR_W) begin : g_bad_cfg
    $error("if_id_pipe_reg: OPCODE_W + 3*REG_W exceeds INSTR_W");
  end

  logic [DATA_W-1:0]   out_data, load_data;
  logic [INSTR_W-1:0]  load_instr;
  logic                load;
  logic                unused_load;
  logic [OPCODE_W-1:0] dec_opcode;
  logic [REG_W-1:0]    dec_rd, dec_rs, dec_rt;

  skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({pc_in, instr}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .load      (load),
    .load_data (load_data)
  );

  assign pc_id       = out_data[DATA_W-1 -: PC_W];
  assign instr_id    = out_data[INSTR_W-1:0];
  assign load_instr  = load_data[INSTR_W-1:0];
  assign unused_load = ^load_data;

  if (INSTR_W == pipe_pkg::INSTR_W && OPCODE_W == pipe_pkg::OPCODE_W &&
      REG_W == pipe_pkg::REG_W) begin : g_pkg_decode
    assign {dec_opcode, dec_rd, dec_rs, dec_rt} =
      decode(load_instr[INSTR_W-1 -: pipe_pkg::FIELD_W]);
  end else begin : g_param_decode
    assign dec_opcode = load_instr[INSTR_W-1 -: OPCODE_W];
    assign dec_rd     = load_instr[INSTR_W-OPCODE_W-1 -: REG_W];
    assign dec_rs     = load_instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
    assign dec_rt     = load_instr[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
  end

  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [REG_W-1:0]    rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;

  // Flush forces a NOP decode but leaves pc_id/instr_id for debug visibility.
  always_comb begin
    opcode_d = opcode_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    if (flush) begin
      opcode_d = NOP_OPCODE;
      rd_d     = '0;
      rs_d     = '0;
      rt_d     = '0;
    end else if (load) begin
      opcode_d = dec_opcode;
      rd_d     = dec_rd;
      rs_d     = dec_rs;
      rt_d     = dec_rt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opcode_q <= NOP_OPCODE;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
    end else begin
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
    end
  end

  assign opcode = opcode_q;
  assign rd     = rd_q;
  assign rs     = rs_q;
  assign rt     = rt_q;

`ifdef IF_ID_PIPE_REG_STATS_EN
  logic [15:0] bubble_count_q, bubble_count_d;

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (out_ready && !out_valid && bubble_count_q != 16'hFFFF)
      bubble_count_d = bubble_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) bubble_count_q <= '0;
    else          bubble_count_q <= bubble_count_d;
  end

  assign bubble_count = bubble_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_if_id_pipe_reg : vector table, corner sequences and randomized   |
// | run against a queue-based model of the IF/ID register. Rev 1.0      |
// +--------------------------------------------------------------------+
module tb_if_id_pipe_reg;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc_in = '0;
  logic        in_ready, out_valid;
  logic [3:0]  opcode;
  logic [5:0]  rd, rs, rt;
  logic [31:0] pc_id, instr_id;

  logic        n_in_valid = 1'b0, n_flush = 1'b0, n_out_ready = 1'b0;
  logic [23:0] n_instr = '0;
  logic [7:0]  n_pc = '0;
  logic        n_in_ready, n_out_valid;
  logic [2:0]  n_opcode;
  logic [4:0]  n_rd, n_rs, n_rt;
  logic [7:0]  n_pc_id;
  logic [23:0] n_instr_id;
`ifdef IF_ID_PIPE_REG_STATS_EN
  logic [15:0] bubble_count, n_bubble_count;
`endif

  always #5 clock = ~clock;

  if_id_pipe_reg dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .pc_id(pc_id),
`ifdef IF_ID_PIPE_REG_STATS_EN
    .bubble_count(bubble_count),
`endif
    .instr_id(instr_id)
  );

  if_id_pipe_reg #(.INSTR_W(24), .PC_W(8), .OPCODE_W(3), .REG_W(5),
                   .NOP_OPCODE(3'b000)) dut_n (
    .clock(clock), .reset_n(reset_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .instr(n_instr), .pc_in(n_pc), .flush(n_flush), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .opcode(n_opcode), .rd(n_rd), .rs(n_rs), .rt(n_rt),
    .pc_id(n_pc_id),
`ifdef IF_ID_PIPE_REG_STATS_EN
    .bubble_count(n_bubble_count),
`endif
    .instr_id(n_instr_id)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic [3:0]  e_opc;
    logic [31:0] e_pc;
    logic        e_rdy;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  localparam logic [31:0] A = 32'h1234_5678, B = 32'h2000_0001, C = 32'h3000_0002;
  localparam logic [31:0] D = 32'h4000_0003, E = 32'h5abc_def0, F = 32'h6000_0007;
  localparam logic [31:0] G = 32'h7000_0009;

  vec_t        vecs [12];
  ent_t        q [$];
  logic [31:0] m_pc, m_ins, pc_ctr, x;
  logic        m_nop;
  int          m_bub;

  initial begin
    vecs[0]  = '{1'b1, A, 32'h40, 1'b0, 1'b0, 1'b1, 4'h1, 32'h40, 1'b1};
    vecs[1]  = '{1'b1, B, 32'h44, 1'b0, 1'b0, 1'b1, 4'h1, 32'h40, 1'b0};
    vecs[2]  = '{1'b1, C, 32'h48, 1'b0, 1'b0, 1'b1, 4'h1, 32'h40, 1'b0};
    vecs[3]  = '{1'b1, C, 32'h48, 1'b0, 1'b1, 1'b1, 4'h2, 32'h44, 1'b1};
    vecs[4]  = '{1'b1, C, 32'h48, 1'b0, 1'b1, 1'b1, 4'h3, 32'h48, 1'b1};
    vecs[5]  = '{1'b0, C, 32'h48, 1'b0, 1'b1, 1'b0, 4'h3, 32'h48, 1'b1};
    vecs[6]  = '{1'b1, D, 32'h4C, 1'b0, 1'b0, 1'b1, 4'h4, 32'h4C, 1'b1};
    vecs[7]  = '{1'b1, E, 32'h50, 1'b0, 1'b0, 1'b1, 4'h4, 32'h4C, 1'b0};
    vecs[8]  = '{1'b1, G, 32'h5C, 1'b1, 1'b0, 1'b0, 4'h0, 32'h4C, 1'b1};
    vecs[9]  = '{1'b1, F, 32'h58, 1'b0, 1'b1, 1'b1, 4'h6, 32'h58, 1'b1};
    vecs[10] = '{1'b1, G, 32'h5C, 1'b1, 1'b1, 1'b0, 4'h0, 32'h58, 1'b1};
    vecs[11] = '{1'b0, G, 32'h5C, 1'b0, 1'b1, 1'b0, 4'h0, 32'h58, 1'b1};

    // Reset values must appear without a clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst opcode", opcode, 0);
    chk("rst pc_id", pc_id, 0);
    chk("rst instr_id", instr_id, 0);
    chk("rst in_ready", in_ready, 1);
    @(negedge clock) reset_n = 1'b1;

    // Streaming, one per cycle, including the worked field example.
    in_valid = 1'b1; instr = A; pc_in = 32'h40; out_ready = 1'b1;
    @(negedge clock);
    chk("str ov", out_valid, 1);
    chk("str opcode", opcode, 4'h1);
    chk("str rd", rd, 6'h08);
    chk("str rs", rs, 6'h34);
    chk("str rt", rt, 6'h15);
    chk("str pc", pc_id, 32'h40);
    for (int k = 1; k < 4; k++) begin
      instr = {4'(k + 1), 28'(k)};
      pc_in = 32'h40 + 32'(4 * k);
      @(negedge clock);
      chk($sformatf("str%0d ov", k), out_valid, 1);
      chk($sformatf("str%0d pc", k), pc_id, 32'h40 + 32'(4 * k));
      chk($sformatf("str%0d instr", k), instr_id, {4'(k + 1), 28'(k)});
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("str drain ov", out_valid, 0);

    // Narrow instance field placement.
    n_in_valid = 1'b1; n_instr = 24'hABCDEF; n_pc = 8'h21; n_out_ready = 1'b1;
    @(negedge clock);
    n_in_valid = 1'b0;
    x = 32'hABCDEF;
    chk("n24 ov", n_out_valid, 1);
    chk("n24 opcode", n_opcode, (x >> 21) & 7);
    chk("n24 rd", n_rd, (x >> 16) & 31);
    chk("n24 rs", n_rs, (x >> 11) & 31);
    chk("n24 rt", n_rt, (x >> 6) & 31);
    chk("n24 pc", n_pc_id, 8'h21);

    // Back-pressure and flush vectors.
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv; instr = vecs[i].ins; pc_in = vecs[i].pc;
      flush = vecs[i].fl; out_ready = vecs[i].ordy;
      @(negedge clock);
      chk($sformatf("vec%0d ov", i), out_valid, vecs[i].e_ov);
      chk($sformatf("vec%0d opcode", i), opcode, vecs[i].e_opc);
      chk($sformatf("vec%0d pc", i), pc_id, vecs[i].e_pc);
      chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_rdy);
    end
    flush = 1'b0;

    // Reset asserted with both registers full, away from any edge.
    in_valid = 1'b1; instr = D; pc_in = 32'h4C; out_ready = 1'b0;
    @(negedge clock);
    instr = E; pc_in = 32'h50;
    @(negedge clock);
    chk("pre-rst in_ready", in_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst opcode", opcode, 0);
    chk("midrst pc_id", pc_id, 0);
    chk("midrst instr_id", instr_id, 0);
    chk("midrst in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clock) reset_n = 1'b1;

    // Randomized traffic against an in-order queue model.
    q.delete();
    m_pc = '0; m_ins = '0; m_nop = 1'b1; m_bub = 0; pc_ctr = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd ov", out_valid, q.size() > 0);
      chk("rnd in_ready", in_ready, q.size() < 2);
      chk("rnd pc_id", pc_id, m_pc);
      chk("rnd instr_id", instr_id, m_ins);
      chk("rnd opcode", opcode, m_nop ? 0 : (m_ins >> 28));
      chk("rnd rd", rd, m_nop ? 0 : ((m_ins >> 22) & 63));
      chk("rnd rt", rt, m_nop ? 0 : ((m_ins >> 10) & 63));
`ifdef IF_ID_PIPE_REG_STATS_EN
      chk("rnd bubbles", bubble_count, m_bub);
`endif
      in_valid  = $urandom_range(0, 99) < 70;
      out_ready = $urandom_range(0, 99) < 60;
      flush     = $urandom_range(0, 99) < 4;
      instr     = $urandom;
      pc_in     = pc_ctr;
      pc_ctr    = pc_ctr + 4;
      if (out_ready && q.size() == 0 && m_bub < 65535) m_bub++;
      if (flush) begin
        q.delete();
        m_nop = 1'b1;
      end else begin
        if (in_valid && q.size() < 2) begin
          if (out_ready && q.size() > 0) void'(q.pop_front());
          q.push_back('{pc_in, instr});
        end else if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
        end
        if (q.size() > 0) begin
          m_pc = q[0].pc; m_ins = q[0].ins; m_nop = 1'b0;
        end
      end
      @(negedge clock);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

`ifdef IF_ID_PIPE_REG_STATS_EN
    reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clock);
    out_ready = 1'b0;
    chk("stats 5 bubbles", bubble_count, 5);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("stats after flush", bubble_count, 5);
    #2 reset_n = 1'b0;
    #1 chk("stats after reset", bubble_count, 0);
    @(negedge clock) reset_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
